// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan update controller.
package scan_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StPulse = 2'd2,
    StHold  = 2'd3
  } state_e;

  // Counter holds 0..width+1 so overshift stays distinguishable from a full word.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/scan_update_ctrl_if.sv
// Scan/update handshake bundle between a driver and the controller.
interface scan_update_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             io_scan_in;
  logic             io_scan_en;
  logic             io_scan_out;
  logic             io_update_req;
  logic [WIDTH-1:0] io_d;
  logic             io_latch_en;
  logic             io_busy;
  logic             io_done;
  logic             io_err;

  modport master (
    output io_scan_in, io_scan_en, io_update_req,
    input  io_scan_out, io_d, io_latch_en, io_busy, io_done, io_err
  );

  modport slave (
    input  io_scan_in, io_scan_en, io_update_req,
    output io_scan_out, io_d, io_latch_en, io_busy, io_done, io_err
  );
endinterface

// File: rtl/scan_shift_reg.sv
// Serial-in shift register with a saturating bit counter and MSB tap.
module scan_shift_reg
  import scan_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CntW = cnt_width(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             shift_en_i,
  input  logic             scan_in_i,
  input  logic             cnt_clr_i,
  output logic [WIDTH-1:0] shift_reg_o,
  output logic [CntW-1:0]  bit_cnt_o,
  output logic             scan_out_o
);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (shift_en_i) begin
      shift_d = {shift_q[WIDTH-2:0], scan_in_i};
      if (cnt_q != CntW'(WIDTH + 1)) cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign shift_reg_o = shift_q;
  assign bit_cnt_o   = cnt_q;
  assign scan_out_o  = shift_q[WIDTH-1];

endmodule

// File: rtl/scan_update_ctrl.sv
// Scan front end: shifts a word in, then transfers it to a shadow register and
// sequences setup / enable pulse / hold for a downstream transparent latch.
module scan_update_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned PULSE_CYCLES = 1
) (
  input  logic                     io_clk,
  input  logic                     io_reset,
  scan_update_ctrl_if.slave        bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam int unsigned PcW  = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  state_e           state_q;
  logic [WIDTH-1:0] shadow_q;
  logic [PcW-1:0]   pulse_cnt_q;
  logic             latch_en_q, busy_q, done_q, err_q;

  logic [WIDTH-1:0] shift_reg;
  logic [CntW-1:0]  bit_cnt;
  logic             idle, shift_en, cnt_clr;

  assign idle     = (state_q == StIdle);
  // An update request wins over a same-cycle shift.
  assign shift_en = idle && bus.io_scan_en && !bus.io_update_req;
  assign cnt_clr  = idle && bus.io_update_req;

  scan_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clk_i       (io_clk),
    .rst_i       (io_reset),
    .shift_en_i  (shift_en),
    .scan_in_i   (bus.io_scan_in),
    .cnt_clr_i   (cnt_clr),
    .shift_reg_o (shift_reg),
    .bit_cnt_o   (bit_cnt),
    .scan_out_o  (bus.io_scan_out)
  );

  // Outputs are registered alongside the state so they track the next state cleanly.
  always_ff @(posedge io_clk) begin
    if (io_reset) begin
      state_q     <= StIdle;
      shadow_q    <= '0;
      pulse_cnt_q <= '0;
      latch_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.io_update_req) begin
            if (bit_cnt == CntW'(WIDTH)) begin
              shadow_q <= shift_reg;
              state_q  <= StSetup;
              busy_q   <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StSetup: begin
          state_q     <= StPulse;
          pulse_cnt_q <= '0;
          latch_en_q  <= 1'b1;
        end
        StPulse: begin
          if (pulse_cnt_q == PcW'(PULSE_CYCLES - 1)) begin
            state_q    <= StHold;
            latch_en_q <= 1'b0;
          end else begin
            pulse_cnt_q <= pulse_cnt_q + PcW'(1);
          end
        end
        StHold: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.io_d        = shadow_q;
  assign bus.io_latch_en = latch_en_q;
  assign bus.io_busy     = busy_q;
  assign bus.io_done     = done_q;
  assign bus.io_err      = err_q;

endmodule

// File: tb/tb_scan_update_ctrl.sv
// Directed bench: two controllers (1- and 3-cycle pulse) each feeding a transparent latch.
module tb_scan_update_ctrl;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   total = 0;
  int   bad   = 0;
  int   done_cnt_a = 0;
  logic [7:0] q_a, q_b;

  always #5 clk = ~clk;

  scan_update_ctrl_if #(.WIDTH(8)) ifa ();
  scan_update_ctrl_if #(.WIDTH(8)) ifb ();

  scan_update_ctrl #(.WIDTH(8), .PULSE_CYCLES(1)) dut_a (
    .io_clk   (clk),
    .io_reset (rst_a),
    .bus      (ifa.slave)
  );

  scan_update_ctrl #(.WIDTH(8), .PULSE_CYCLES(3)) dut_b (
    .io_clk   (clk),
    .io_reset (rst_b),
    .bus      (ifb.slave)
  );

  // Behavioural stand-ins for the downstream scan Latch.
  always_latch if (ifa.io_latch_en) q_a = ifa.io_d;
  always_latch if (ifb.io_latch_en) q_b = ifb.io_d;

  always @(posedge clk) if (ifa.io_done) done_cnt_a = done_cnt_a + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_a(input logic [7:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ifa.io_scan_in = w[i];
      ifa.io_scan_en = 1'b1;
      tick();
    end
    ifa.io_scan_en = 1'b0;
  endtask

  task automatic req_a();
    ifa.io_update_req = 1'b1;
    tick();
    ifa.io_update_req = 1'b0;
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
  endtask

  int dc0;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.io_scan_in = 0; ifa.io_scan_en = 0; ifa.io_update_req = 0;
    ifb.io_scan_in = 0; ifb.io_scan_en = 0; ifb.io_update_req = 0;
    tick(); tick();
    chk("rst_latch_en", 32'(ifa.io_latch_en), 0);
    chk("rst_busy",     32'(ifa.io_busy), 0);
    chk("rst_d",        32'(ifa.io_d), 0);
    chk("rst_done_err", 32'({ifa.io_done, ifa.io_err}), 0);
    chk("rst_scan_out", 32'(ifa.io_scan_out), 0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Nominal update of 8'hA5.
    shift_a(8'hA5, 8);
    chk("nom_bit_cnt",  32'(dut_a.bit_cnt), 8);
    chk("nom_scan_out", 32'(ifa.io_scan_out), 1);
    req_a();
    chk("nom_d_p1",     32'(ifa.io_d), 32'hA5);
    chk("nom_busy_p1",  32'(ifa.io_busy), 1);
    chk("nom_len_p1",   32'(ifa.io_latch_en), 0);
    tick();
    chk("nom_len_p2",   32'(ifa.io_latch_en), 1);
    tick();
    chk("nom_len_p3",   32'(ifa.io_latch_en), 0);
    chk("nom_done_p3",  32'(ifa.io_done), 0);
    tick();
    chk("nom_done_p4",  32'(ifa.io_done), 1);
    chk("nom_busy_p4",  32'(ifa.io_busy), 0);
    chk("nom_q",        32'(q_a), 32'hA5);
    shift_a(8'h5A, 8);
    chk("nom_q_hold",   32'(q_a), 32'hA5);
    chk("nom_d_hold",   32'(ifa.io_d), 32'hA5);

    // Short shift: 7 bits then update.
    reset_a();
    shift_a(8'h7F, 7);
    req_a();
    chk("short_err",     32'(ifa.io_err), 1);
    chk("short_len",     32'(ifa.io_latch_en), 0);
    chk("short_d",       32'(ifa.io_d), 0);
    chk("short_bit_cnt", 32'(dut_a.bit_cnt), 0);
    chk("short_busy",    32'(ifa.io_busy), 0);
    tick();
    chk("short_err_gone", 32'(ifa.io_err), 0);

    // Overshift: 9 ones.
    reset_a();
    shift_a(8'hFF, 7);
    chk("over_scan_out7", 32'(ifa.io_scan_out), 0);
    shift_a(8'hFF, 1);
    chk("over_scan_out8", 32'(ifa.io_scan_out), 1);
    shift_a(8'hFF, 1);
    chk("over_bit_cnt",   32'(dut_a.bit_cnt), 9);
    req_a();
    chk("over_err",       32'(ifa.io_err), 1);
    chk("over_busy",      32'(ifa.io_busy), 0);

    // Busy lockout during PULSE.
    reset_a();
    shift_a(8'hA5, 8);
    dc0 = done_cnt_a;
    req_a();
    tick();
    chk("lock_in_pulse", 32'(ifa.io_latch_en), 1);
    ifa.io_scan_en = 1'b1; ifa.io_scan_in = 1'b0; ifa.io_update_req = 1'b1;
    tick();
    ifa.io_scan_en = 1'b0; ifa.io_update_req = 1'b0;
    chk("lock_shift_reg", 32'(dut_a.shift_reg), 32'hA5);
    chk("lock_bit_cnt",   32'(dut_a.bit_cnt), 0);
    tick();
    chk("lock_done",      32'(ifa.io_done), 1);
    tick();
    chk("lock_busy_after", 32'(ifa.io_busy), 0);
    tick(); tick(); tick();
    chk("lock_no_second", 32'({ifa.io_busy, ifa.io_latch_en}), 0);
    chk("lock_done_count", 32'(done_cnt_a - dc0), 1);

    // Reset in the middle of PULSE.
    shift_a(8'h3C, 8);
    req_a();
    tick();
    chk("mid_in_pulse", 32'(ifa.io_latch_en), 1);
    reset_a();
    chk("mid_len",  32'(ifa.io_latch_en), 0);
    chk("mid_busy", 32'(ifa.io_busy), 0);
    chk("mid_d",    32'(ifa.io_d), 0);
    shift_a(8'h3C, 8);
    req_a();
    chk("mid_d_p1",   32'(ifa.io_d), 32'h3C);
    tick();
    chk("mid_len_p2", 32'(ifa.io_latch_en), 1);
    tick(); tick();
    chk("mid_done_p4", 32'(ifa.io_done), 1);
    chk("mid_q",       32'(q_a), 32'h3C);

    // Three-cycle pulse on the second instance.
    for (int i = 7; i >= 0; i--) begin
      ifb.io_scan_in = 8'h5A >> i;
      ifb.io_scan_en = 1'b1;
      tick();
    end
    ifb.io_scan_en = 1'b0;
    ifb.io_update_req = 1'b1;
    tick();
    ifb.io_update_req = 1'b0;
    chk("p3_len_p1", 32'(ifb.io_latch_en), 0);
    chk("p3_d_p1",   32'(ifb.io_d), 32'h5A);
    tick();
    chk("p3_len_p2", 32'(ifb.io_latch_en), 1);
    tick();
    chk("p3_len_p3", 32'(ifb.io_latch_en), 1);
    tick();
    chk("p3_len_p4", 32'(ifb.io_latch_en), 1);
    tick();
    chk("p3_len_p5", 32'(ifb.io_latch_en), 0);
    chk("p3_done_p5", 32'(ifb.io_done), 0);
    tick();
    chk("p3_done_p6", 32'(ifb.io_done), 1);
    chk("p3_busy_p6", 32'(ifb.io_busy), 0);
    chk("p3_q",       32'(q_b), 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_update_ctrl.md
Name: scan_update_ctrl

Overview:
- Scan-chain front end that sits directly upstream of the scan `Latch` stage. Its `io_d` and `io_latch_en` outputs drive the latch's `io_d` and `io_clk`.
- Serially shifts `WIDTH` bits into a shift register and counts them.
- On request, copies the shift register into a shadow register and sequences a clean enable pulse around stable data, so the transparent latch captures glitch-free.

Parameters:
- WIDTH, 8, scan word width; must be at least 2.
- PULSE_CYCLES, 1, number of cycles `io_latch_en` stays high; must be at least 1.

Ports:
- io_clk  in  1  sole clock; all state updates on its rising edge.
- io_reset  in  1  synchronous, active-high reset.
- io_scan_in  in  1  serial data bit.
- io_scan_en  in  1  when high in IDLE, shifts `io_scan_in` in on this edge.
- io_scan_out  out  1  equals shift_reg[WIDTH-1]; used for daisy-chaining.
- io_update_req  in  1  single-cycle request to transfer the shifted word to the latch.
- io_d  out  WIDTH  shadow register; connects to the latch `io_d`.
- io_latch_en  out  1  connects to the latch `io_clk`; the latch is transparent while this is high.
- io_busy  out  1  high in any state other than IDLE.
- io_done  out  1  one-cycle pulse when an update sequence completes.
- io_err  out  1  one-cycle pulse when an update is rejected because of a bad bit count.

Behaviour:
- Reset (synchronous, active-high):
  - shift_reg, shadow, bit_cnt, pulse_cnt cleared to 0.
  - State set to IDLE.
  - All outputs 0.
  - A reset in any state aborts the sequence. `io_latch_en` drops to 0 on the next edge.
- Shift (IDLE only, `io_scan_en` high):
  - shift_reg <= {shift_reg[WIDTH-2:0], io_scan_in}, so the first bit shifted ends up in the MSB after `WIDTH` shifts.
  - bit_cnt increments and saturates at WIDTH+1, which marks overshift.
  - `io_scan_en` is ignored while `io_busy` is high: no shift and no count.
- bit_cnt width is $clog2(WIDTH+2).
- FSM states: IDLE, SETUP, PULSE, HOLD.
  - IDLE, `io_update_req` high, bit_cnt == WIDTH:
    - shadow <= shift_reg, making the new value visible on `io_d` next cycle.
    - bit_cnt <= 0.
    - Go to SETUP.
  - IDLE, `io_update_req` high, bit_cnt != WIDTH:
    - `io_err` pulses next cycle; bit_cnt <= 0.
    - shadow, shift_reg and `io_latch_en` are untouched.
    - Stay in IDLE.
  - IDLE, `io_update_req` and `io_scan_en` both high:
    - The update takes priority; the shift is dropped.
    - The count check uses the pre-shift bit_cnt.
  - SETUP: `io_latch_en` = 0 and `io_d` stable. After 1 cycle, go to PULSE with pulse_cnt = 0.
  - PULSE: `io_latch_en` = 1. pulse_cnt increments; when pulse_cnt == PULSE_CYCLES-1, go to HOLD.
  - HOLD: `io_latch_en` = 0 and `io_d` still stable. After 1 cycle, go to IDLE with `io_done` = 1 for that cycle.
- `io_update_req` is ignored outside IDLE.
- `io_latch_en`, `io_done`, `io_err` and `io_busy` are registered outputs decoded from the next state. They are glitch-free.
- Latency, measured from the edge that samples `io_update_req`:
  - `io_d` valid at +1.
  - `io_latch_en` high at +2 through +(1+PULSE_CYCLES).
  - `io_done` at +(3+PULSE_CYCLES).
  - `io_busy` high from +1 until `io_done`.
- `io_d` changes only on the IDLE-to-SETUP transition, so it never changes while `io_latch_en` is high.

Decomposition:
- Package scan_pkg:
  - State enum, 2-bit encoding: IDLE=0, SETUP=1, PULSE=2, HOLD=3.
  - A function computing the counter width from WIDTH.
- One natural sub-module: scan_shift_reg, containing shift_reg, bit_cnt and the `io_scan_out` tap.
- The FSM, shadow register and pulse counter live in the top level.
- The testbench instantiates scan_update_ctrl feeding the existing `Latch` to check end-to-end behaviour.

Test Plan:
- Nominal update, WIDTH=8, PULSE_CYCLES=1:
  - Stimulus: shift 1,0,1,0,0,1,0,1 MSB-first, then pulse `io_update_req`.
  - Required: `io_d` = 8'hA5 at +1; `io_latch_en` high for exactly 1 cycle at +2; `io_done` at +4.
  - Required: the attached latch `io_q` = 8'hA5, and it is still 8'hA5 after `io_d` inputs toggle in IDLE.
- Short shift:
  - Stimulus: 7 shifts, then `io_update_req`.
  - Required: `io_err` pulse at +1; no `io_latch_en`; `io_d` keeps its previous value (8'h00 after reset); bit_cnt reads 0.
- Overshift:
  - Stimulus: 9 shifts of 1, then `io_update_req`.
  - Required: `io_err` pulse; `io_scan_out` = 1 after the 8th shift.
- Busy lockout:
  - Stimulus: during the PULSE state, assert `io_scan_en` and `io_update_req`.
  - Required: shift_reg and bit_cnt unchanged; no second sequence; exactly one `io_done`.
- PULSE_CYCLES=3:
  - Required: `io_latch_en` high for exactly 3 consecutive cycles; `io_done` at +6.
- Reset mid-PULSE:
  - Stimulus: assert `io_reset` for one cycle while in PULSE.
  - Required: next edge `io_latch_en`=0, `io_busy`=0, `io_d`=8'h00; a subsequent clean 8-bit shift and update completes normally.
